// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//   Shared constants and helpers for the MM:SS stopwatch:
//   - BCD digit limits (MAX_TENS / MAX_ONES)
//   - active-low 7-segment table, bit order {g,f,e,d,c,b,a}
//   - blank pattern for codes that are not valid BCD digits
//   - BCD increment of a two-digit 00..59 field
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    localparam logic [3:0] MAX_TENS  = 4'd5;
    localparam logic [3:0] MAX_ONES  = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 0 is the rightmost entry.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        if (d > MAX_ONES) begin
            s = SEG_BLANK;
        end else begin
            s = SEG_TABLE[d];
        end
        return s;
    endfunction

    // Increment a {tens, ones} BCD pair modulo 60; 59 wraps to 00.
    function automatic logic [7:0] bcd_inc_mod60(input logic [3:0] tens,
                                                 input logic [3:0] ones);
        logic [3:0] t;
        logic [3:0] o;
        t = tens;
        o = ones + 4'd1;
        if (ones == MAX_ONES) begin
            o = 4'd0;
            t = (tens == MAX_TENS) ? 4'd0 : tens + 4'd1;
        end
        return {t, o};
    endfunction

endpackage

// File: rtl/stopwatch_debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
//   Two-flop synchronizer followed by a stability counter. The output takes
//   the synchronized value once that value has disagreed with the output for
//   STABLE_COUNT cycles; any agreement in between restarts the count. Raw edge
//   to output edge is 2 + STABLE_COUNT cycles.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset (all state to 0)
//   raw_in  in  asynchronous raw input
//   db_out  out debounced, synchronous level
// -----------------------------------------------------------------------------
module debouncer
    import stopwatch_pkg::*;
#(
    parameter int unsigned STABLE_COUNT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic db_out
);

    localparam int unsigned CNT_W = $clog2(STABLE_COUNT + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(STABLE_COUNT)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_out = db_q;

endmodule

// File: rtl/stopwatch_top.sv
// -----------------------------------------------------------------------------
// stopwatch_top
//   Four-digit MM:SS stopwatch (00:00..59:59) driving a multiplexed
//   common-anode 7-segment display. Four debounced user inputs: clear,
//   pause/resume, adjust mode and adjust field select. In adjust mode the
//   selected field (seconds or minutes) steps modulo 60 on the 2 Hz tick.
//   The digit registers are visible internally as mt, mo, st, so (BCD).
// Optional feature:
//   STOPWATCH_BLINK_EN - when defined, the anodes of the selected field are
//   blanked in adjust mode while the blink flag is 0. When undefined the blink
//   divider is not built.
// Ports:
//   clk_100mhz     in   system clock
//   rst_n          in   asynchronous active-low reset
//   btn_reset_raw  in   clear button, raw, active-high
//   btn_pause_raw  in   pause/resume button, raw, active-high
//   sw_adj_raw     in   adjust-mode switch, raw (1 = adjust)
//   sw_sel_raw     in   adjust field select, raw (1 = seconds, 0 = minutes)
//   seg[6:0]       out  cathodes {g,f,e,d,c,b,a}, active-low, registered
//   an[3:0]        out  anodes, active-low, an[3] = minutes tens, registered
//   dp             out  decimal point, active-low, registered
// -----------------------------------------------------------------------------
module stopwatch_top
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV_1HZ      = 100_000_000,
    parameter int unsigned DIV_2HZ      = 50_000_000,
    parameter int unsigned DIV_FAST     = 100_000,
    parameter int unsigned DIV_BLINK    = 25_000_000,
    parameter int unsigned STABLE_COUNT = 1_000_000
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       btn_reset_raw,
    input  logic       btn_pause_raw,
    input  logic       sw_adj_raw,
    input  logic       sw_sel_raw,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    // The slow dividers share one counter width sized for the largest divisor.
    localparam int unsigned MAX_12   = (DIV_1HZ > DIV_2HZ) ? DIV_1HZ : DIV_2HZ;
    localparam int unsigned SLOW_MAX = (MAX_12 > DIV_BLINK) ? MAX_12 : DIV_BLINK;
    localparam int unsigned SLOW_W   = $clog2(SLOW_MAX + 1);
    localparam int unsigned FAST_W   = $clog2(DIV_FAST + 1);

    // ---------------- debounced inputs ----------------
    logic clr_db, pause_db, adj_db, sel_db;

    debouncer #(.STABLE_COUNT(STABLE_COUNT)) u_db_rst (
        .clk(clk_100mhz), .rst_n(rst_n), .raw_in(btn_reset_raw), .db_out(clr_db)
    );
    debouncer #(.STABLE_COUNT(STABLE_COUNT)) u_db_pause (
        .clk(clk_100mhz), .rst_n(rst_n), .raw_in(btn_pause_raw), .db_out(pause_db)
    );
    debouncer #(.STABLE_COUNT(STABLE_COUNT)) u_db_adj (
        .clk(clk_100mhz), .rst_n(rst_n), .raw_in(sw_adj_raw), .db_out(adj_db)
    );
    debouncer #(.STABLE_COUNT(STABLE_COUNT)) u_db_sel (
        .clk(clk_100mhz), .rst_n(rst_n), .raw_in(sw_sel_raw), .db_out(sel_db)
    );

    // ---------------- state ----------------
    logic [SLOW_W-1:0] cnt_1hz_q, cnt_1hz_d;
    logic [SLOW_W-1:0] cnt_2hz_q, cnt_2hz_d;
    logic [FAST_W-1:0] cnt_fast_q, cnt_fast_d;
    logic              tick_1hz, tick_2hz, tick_fast;

    logic [3:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
    logic [3:0] mt, mo, st, so;
    logic       paused_q, paused_d;
    logic       pause_prev_q, pause_prev_d;
    logic       pause_pulse;
    logic       sec_wrap;

    logic [1:0] idx_q, idx_d;
    logic [3:0] digit;
    logic [6:0] seg_q, seg_d;
    logic [3:0] an_q, an_d;
    logic       dp_q, dp_d;
    logic       blank_sel;

    assign mt = mt_q;
    assign mo = mo_q;
    assign st = st_q;
    assign so = so_q;

    // ---------------- dividers ----------------
    always_comb begin
        tick_1hz   = (cnt_1hz_q == SLOW_W'(DIV_1HZ - 1));
        tick_2hz   = (cnt_2hz_q == SLOW_W'(DIV_2HZ - 1));
        tick_fast  = (cnt_fast_q == FAST_W'(DIV_FAST - 1));
        cnt_1hz_d  = tick_1hz  ? '0 : cnt_1hz_q + 1'b1;
        cnt_2hz_d  = tick_2hz  ? '0 : cnt_2hz_q + 1'b1;
        cnt_fast_d = tick_fast ? '0 : cnt_fast_q + 1'b1;
        // Clearing holds the counting dividers so the first tick after the
        // clear is a full period away.
        if (clr_db) begin
            cnt_1hz_d = '0;
            cnt_2hz_d = '0;
        end
    end

`ifdef STOPWATCH_BLINK_EN
    logic [SLOW_W-1:0] cnt_blink_q, cnt_blink_d;
    logic              blink_q, blink_d;

    always_comb begin
        cnt_blink_d = cnt_blink_q + 1'b1;
        blink_d     = blink_q;
        if (cnt_blink_q == SLOW_W'(DIV_BLINK - 1)) begin
            cnt_blink_d = '0;
            blink_d     = ~blink_q;
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_blink_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            cnt_blink_q <= cnt_blink_d;
            blink_q     <= blink_d;
        end
    end

    assign blank_sel = adj_db & ~blink_q;
`else
    assign blank_sel = 1'b0;
`endif

    // ---------------- time counter ----------------
    assign pause_pulse = pause_db & ~pause_prev_q;

    always_comb begin
        mt_d         = mt_q;
        mo_d         = mo_q;
        st_d         = st_q;
        so_d         = so_q;
        paused_d     = paused_q;
        pause_prev_d = pause_db;
        sec_wrap     = (st_q == MAX_TENS) && (so_q == MAX_ONES);
        if (clr_db) begin
            mt_d     = 4'd0;
            mo_d     = 4'd0;
            st_d     = 4'd0;
            so_d     = 4'd0;
            paused_d = 1'b0;
        end else begin
            if (pause_pulse) begin
                paused_d = ~paused_q;
            end
            if (adj_db) begin
                // Adjust steps one field only; no carry between fields.
                if (tick_2hz) begin
                    if (sel_db) begin
                        {st_d, so_d} = bcd_inc_mod60(st_q, so_q);
                    end else begin
                        {mt_d, mo_d} = bcd_inc_mod60(mt_q, mo_q);
                    end
                end
            end else if (tick_1hz && !paused_q) begin
                {st_d, so_d} = bcd_inc_mod60(st_q, so_q);
                if (sec_wrap) begin
                    {mt_d, mo_d} = bcd_inc_mod60(mt_q, mo_q);
                end
            end
        end
    end

    // ---------------- display ----------------
    always_comb begin
        idx_d = tick_fast ? idx_q + 2'd1 : idx_q;
        case (idx_q)
            2'd0:    digit = so;
            2'd1:    digit = st;
            2'd2:    digit = mo;
            default: digit = mt;
        endcase
        seg_d = bcd_to_seg(digit);
        an_d  = ~(4'b0001 << idx_q);
        dp_d  = (idx_q != 2'd2);
        // idx 0/1 are the seconds digits, idx 2/3 the minutes digits.
        if (blank_sel && (sel_db ? !idx_q[1] : idx_q[1])) begin
            an_d = 4'b1111;
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_1hz_q    <= '0;
            cnt_2hz_q    <= '0;
            cnt_fast_q   <= '0;
            mt_q         <= 4'd0;
            mo_q         <= 4'd0;
            st_q         <= 4'd0;
            so_q         <= 4'd0;
            paused_q     <= 1'b0;
            pause_prev_q <= 1'b0;
            idx_q        <= 2'd0;
            seg_q        <= SEG_BLANK;
            an_q         <= 4'b1111;
            dp_q         <= 1'b1;
        end else begin
            cnt_1hz_q    <= cnt_1hz_d;
            cnt_2hz_q    <= cnt_2hz_d;
            cnt_fast_q   <= cnt_fast_d;
            mt_q         <= mt_d;
            mo_q         <= mo_d;
            st_q         <= st_d;
            so_q         <= so_d;
            paused_q     <= paused_d;
            pause_prev_q <= pause_prev_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_top.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_top
//   Directed bench with small dividers (1 Hz = 10, 2 Hz = 5, scan = 2,
//   blink = 7, debounce = 2). edge_n counts rising edges since rst_n was last
//   released; at(t) parks on the falling edge after edge t, where outputs are
//   sampled and inputs are driven (sampled by the DUT at edge t + 1).
// -----------------------------------------------------------------------------
module tb_stopwatch_top;

    logic       clk_100mhz;
    logic       rst_n;
    logic       btn_reset_raw;
    logic       btn_pause_raw;
    logic       sw_adj_raw;
    logic       sw_sel_raw;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n;

    logic [3:0] scan_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    stopwatch_top #(
        .DIV_1HZ(10), .DIV_2HZ(5), .DIV_FAST(2), .DIV_BLINK(7), .STABLE_COUNT(2)
    ) dut (
        .clk_100mhz   (clk_100mhz),
        .rst_n        (rst_n),
        .btn_reset_raw(btn_reset_raw),
        .btn_pause_raw(btn_pause_raw),
        .sw_adj_raw   (sw_adj_raw),
        .sw_sel_raw   (sw_sel_raw),
        .seg          (seg),
        .an           (an),
        .dp           (dp)
    );

    // ---------------- clock / reset bookkeeping ----------------
    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    always @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver / checker tasks ----------------
    task automatic at(input int t);
        while (edge_n < t) @(negedge clk_100mhz);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input logic [15:0] exp);
        chk(tag, 32'({dut.mt, dut.mo, dut.st, dut.so}), 32'(exp));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n         = 1'b0;
        btn_reset_raw = 1'b0;
        btn_pause_raw = 1'b0;
        sw_adj_raw    = 1'b0;
        sw_sel_raw    = 1'b0;
        repeat (3) @(negedge clk_100mhz);

        chk("rst_an", 32'(an), 32'h0000000F);
        chk("rst_seg", 32'(seg), 32'h0000007F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk_time("rst_time", 16'h0000);
        chk("rst_paused", 32'(dut.paused_q), 32'd0);
        rst_n = 1'b1;

        // Scan order right after release; all digits are 0.
        for (int k = 1; k <= 8; k++) begin
            at(k);
            chk("scan_an", 32'(an), 32'(scan_an[(k - 1) / 2]));
            chk("scan_dp", 32'(dp), ((k - 1) / 2 == 2) ? 32'd0 : 32'd1);
            chk("scan_seg0", 32'(seg), 32'h00000040);
        end

        at(9);  chk_time("first_tick_pre", 16'h0000);
        at(10); chk_time("first_tick", 16'h0001);
        at(39); chk_time("count_39", 16'h0003);
        at(40); chk_time("count_40", 16'h0004);

        // Pause press of 4 cycles, then idle.
        btn_pause_raw = 1'b1;
        at(44); btn_pause_raw = 1'b0;
        at(50); chk_time("paused_hold", 16'h0004);
        chk("paused_set", 32'(dut.paused_q), 32'd1);
        at(64); chk_time("paused_hold_64", 16'h0004);
        btn_pause_raw = 1'b1;
        at(68); btn_pause_raw = 1'b0;
        at(75); chk("paused_clr", 32'(dut.paused_q), 32'd0);
        chk_time("resume_pre", 16'h0004);
        at(80); chk_time("resume", 16'h0005);

        // Pause again so the clear has a paused state to drop.
        btn_pause_raw = 1'b1;
        at(84); btn_pause_raw = 1'b0;
        at(90); chk("paused_again", 32'(dut.paused_q), 32'd1);
        chk_time("paused_again_t", 16'h0005);

        // Clear held 8 cycles while counting (paused).
        btn_reset_raw = 1'b1;
        at(94); chk("db_rise_pre", 32'(dut.u_db_rst.db_out), 32'd0);
        at(95); chk("db_rise", 32'(dut.u_db_rst.db_out), 32'd1);
        chk_time("clr_pre", 16'h0005);
        at(96); chk_time("clr_time", 16'h0000);
        chk("clr_paused", 32'(dut.paused_q), 32'd0);
        at(98); btn_reset_raw = 1'b0;
        at(102); chk("db_fall_pre", 32'(dut.u_db_rst.db_out), 32'd1);
        at(103); chk("db_fall", 32'(dut.u_db_rst.db_out), 32'd0);
        at(112); chk_time("div_held", 16'h0000);
        at(113); chk_time("div_restart", 16'h0001);

        // Adjust seconds.
        sw_adj_raw = 1'b1;
        sw_sel_raw = 1'b1;
        at(122); chk_time("adj_pre", 16'h0001);
        at(123); chk_time("adj_first", 16'h0002);
        at(128); chk_time("adj_second", 16'h0003);
        at(403); chk_time("adj_s58", 16'h0058);
        at(408); chk_time("adj_s59", 16'h0059);
        at(413); chk_time("adj_s00", 16'h0000);
        at(417); sw_sel_raw = 1'b0;
        at(418); chk_time("adj_s01", 16'h0001);
        at(423); chk_time("adj_m01", 16'h0101);
        at(428); chk_time("adj_m02", 16'h0201);
        at(433); chk_time("adj_m03", 16'h0301);

        // Clear held 8 cycles during adjust.
        btn_reset_raw = 1'b1;
        at(441); btn_reset_raw = 1'b0;
        at(442); chk_time("clr_adj", 16'h0000);
        chk("clr_adj_paused", 32'(dut.paused_q), 32'd0);
        at(450); chk_time("clr_adj_held", 16'h0000);
        at(451); chk_time("clr_adj_first", 16'h0100);

        // One-cycle glitch on every raw input.
        btn_reset_raw = 1'b1;
        btn_pause_raw = 1'b1;
        sw_adj_raw    = 1'b0;
        sw_sel_raw    = 1'b1;
        at(452);
        btn_reset_raw = 1'b0;
        btn_pause_raw = 1'b0;
        sw_adj_raw    = 1'b1;
        sw_sel_raw    = 1'b0;
        at(456); chk_time("glitch_m02", 16'h0200);
        chk("glitch_paused", 32'(dut.paused_q), 32'd0);
        at(461); chk_time("glitch_m03", 16'h0300);

        // Minutes to 59, then seconds to 59.
        at(737); sw_sel_raw = 1'b1;
        at(741); chk_time("adj_m59", 16'h5900);
        at(746); chk_time("adj_nocarry", 16'h5901);

        for (int k = 800; k < 828; k++) begin
            at(k);
`ifdef STOPWATCH_BLINK_EN
            if (((k - 1) / 7) % 2 == 0) chk("blink_blank", 32'(an[1:0]), 32'd3);
            else                        chk("blink_lit", 32'(an == 4'hF), 32'd0);
`else
            chk("adj_lit", 32'(an == 4'hF), 32'd0);
`endif
        end

        at(1032); sw_adj_raw = 1'b0;
        at(1036); chk_time("preload_5959", 16'h5959);
        at(1044); chk("seg_5", 32'(seg), 32'h00000012);
        chk("an_st", 32'(an), 32'h0000000D);
        chk("dp_off", 32'(dp), 32'd1);
        at(1045); chk_time("hold_5959", 16'h5959);
        chk("seg_9", 32'(seg), 32'h00000010);
        chk("an_mo", 32'(an), 32'h0000000B);
        chk("dp_on", 32'(dp), 32'd0);
        at(1046); chk_time("wrap_0000", 16'h0000);
        at(1636); chk_time("preload_0059", 16'h0059);
        at(1646); chk_time("carry_0100", 16'h0100);

        // Reset mid-operation.
        at(1650);
        rst_n = 1'b0;
        #1;
        chk("rst2_an", 32'(an), 32'h0000000F);
        chk("rst2_seg", 32'(seg), 32'h0000007F);
        chk("rst2_dp", 32'(dp), 32'd1);
        chk_time("rst2_time", 16'h0000);
        @(negedge clk_100mhz);
        rst_n = 1'b1;
        at(9);  chk_time("rst2_pre", 16'h0000);
        at(10); chk_time("rst2_first", 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_top.md
# stopwatch_top

Four-digit MM:SS stopwatch for a 100 MHz FPGA board with a multiplexed common-anode 7-segment display. It debounces four raw user inputs and derives 1 Hz, 2 Hz, display-scan and blink enables from the single clock. It counts 00:00 to 59:59 with pause and reset, supports manual minute/second adjust, and drives the seg/an/dp pins.

## Interface
- DIV_1HZ, 100_000_000: clock cycles per count tick.
- DIV_2HZ, 50_000_000: cycles per adjust-increment tick.
- DIV_FAST, 100_000: cycles per display-scan step.
- DIV_BLINK, 25_000_000: cycles per blink-phase toggle.
- STABLE_COUNT, 1_000_000: consecutive stable samples a debouncer needs before its output changes.
- clk_100mhz  in  1  system clock; the only clock.
- rst_n  in  1  system reset; asynchronous, active-low.
- btn_reset_raw  in  1  user clear button, raw, active-high.
- btn_pause_raw  in  1  pause/resume button, raw, active-high.
- sw_adj_raw  in  1  adjust-mode switch, raw; 1 = adjust.
- sw_sel_raw  in  1  adjust field select, raw; 1 = seconds, 0 = minutes.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- an  out  4  anodes, active-low; an[3] = minutes tens … an[0] = seconds ones.
- dp  out  1  decimal point, active-low.

## Operation
- Every raw input passes through a 2-flop synchronizer and then a debouncer. The debounced output takes the synchronized value only after that value has differed from the output for STABLE_COUNT consecutive cycles.
- Pause: each rising edge of the debounced pause input makes a 1-cycle pulse that toggles `paused`.
- User clear (debounced reset = 1):
  - digits forced to 00:00, `paused` cleared;
  - 1 Hz and 2 Hz dividers held at 0;
  - clear has priority over every other event in the same cycle.
- Counting: when adj = 0 and not paused, each 1 Hz tick increments the time.
  - seconds ones 9→0 carries into seconds tens; tens 5→0 carries into minutes;
  - 59:59 → 00:00.
- Adjust (adj = 1): 1 Hz counting is suspended.
  - Each 2 Hz tick increments the selected field (sel = 1 seconds, sel = 0 minutes) modulo 60, with no carry into the other field.
  - `paused` is retained across adjust; counting resumes per `paused` on exit.
- Digit registers are 4-bit BCD and visible at top level as mt, mo, st, so.
- Display: a 2-bit scan index advances on each fast tick, 0→1→2→3→0.
  - index i drives an = ~(1<<i) and shows so, st, mo, mt respectively;
  - seg decodes BCD 0–9 active-low (0 → 7'b1000000, 8 → 7'b0000000); codes above 9 give all segments off;
  - dp = 0 (lit) only while index 2 is active, as the MM.SS separator; otherwise 1.

## Timing
- Divider counters run 0..DIV−1. The tick is a 1-cycle pulse in the cycle the counter equals DIV−1, then the counter wraps to 0. The blink flag toggles on its own tick.
- Digit update: registered, one cycle after the tick.
- Debounce latency from a raw edge to the debounced edge: 2 + STABLE_COUNT cycles. Pulses shorter than STABLE_COUNT are rejected.
- Outputs (seg, an, dp) are registered.
- While rst_n is low: digits 0, paused 0, all dividers and debouncers 0, scan index 0, blink flag 0, an = 4'b1111, seg = 7'b1111111, dp = 1.
- Releasing rst_n mid-operation restarts all counters from 0; no state survives.

## Configuration
- STOPWATCH_BLINK_EN defined: in adjust mode, both digits of the selected field are blanked (their an stays 1) while the blink flag is 0.
- STOPWATCH_BLINK_EN undefined: no blanking. The blink divider is not built and DIV_BLINK is ignored.

## Structure
- Shared package stopwatch_pkg holds:
  - the BCD-to-7-segment constant table;
  - the blank pattern 7'h7F;
  - the MAX_TENS = 5 and MAX_ONES = 9 constants.
- One sub-module, `debouncer` (synchronizer + stable counter, parameter STABLE_COUNT), is instantiated four times as u_db_rst, u_db_pause, u_db_adj and u_db_sel.
- Dividers, counter and display mux stay inline in the top.

## Test plan
All scenarios use DIV_1HZ = 10, DIV_2HZ = 5, DIV_FAST = 2, DIV_BLINK = 7, STABLE_COUNT = 2.
- Release rst_n with no button pressed -> digits 00:00, and so reaches 4 after 40 further cycles (one increment every 10 cycles, starting 10 cycles after release).
- Pause press of 4 high cycles, then 20 idle cycles -> digits frozen; a second press -> counting resumes from the frozen value.
- Preload 00:59 and 59:59 -> next 1 Hz tick gives 01:00 and 00:00 respectively.
- adj = 1, sel = 1, starting at 00:58 -> seconds go 59, 00, 01 every 5 cycles; minutes stay 00. Then sel = 0 -> minutes increment every 5 cycles, seconds unchanged.
- btn_reset_raw held for 8 cycles during counting and during adjust -> digits 00:00, paused = 0. A 1-cycle glitch on any raw input -> no effect.
- Scan check -> an cycles 1110, 1101, 1011, 0111 every 2 cycles; dp = 0 only with 1011; seg for digit 0 = 1000000. With STOPWATCH_BLINK_EN, the selected field's anodes stay 1 for 7 of every 14 cycles.
